// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator execution unit.
// Holds the 3-bit model codes driven by the opcode decoder, the ALU and
// unary function codes taken from the raw opcode, and the sequencer states.
package acc_pkg;

  // Model codes carried on acc_ctrl (shared with the decoder).
  localparam logic [2:0] CTRL_INV   = 3'b000;
  localparam logic [2:0] CTRL_ALU   = 3'b001;
  localparam logic [2:0] CTRL_UNARY = 3'b010;
  localparam logic [2:0] CTRL_EQ    = 3'b011;
  localparam logic [2:0] CTRL_JMP   = 3'b100;
  localparam logic [2:0] CTRL_ST    = 3'b101;
  localparam logic [2:0] CTRL_LD    = 3'b110;
  localparam logic [2:0] CTRL_LWR   = 3'b111;

  // op[5:3] group that selects add-immediate inside the ALU model.
  localparam logic [2:0] OP_GRP_ADDI = 3'b010;

  // op[1:0] register-operand ALU functions.
  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_SUB = 2'b01;
  localparam logic [1:0] FN_AND = 2'b10;
  localparam logic [1:0] FN_OR  = 2'b11;

  // op[2:0] unary functions.
  localparam logic [2:0] UN_SHL = 3'b101;
  localparam logic [2:0] UN_SHR = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MEM    = 2'b01,
    RETIRE = 2'b10
  } state_e;

endpackage

// File: rtl/acc_alu.sv
// Combinational next-accumulator logic for the ALU and unary models.
// Ports:
//   i_ctrl     model code (only CTRL_ALU / CTRL_UNARY change the result)
//   i_op       raw opcode, function select
//   i_acc      current accumulator
//   i_rs_data  register operand
//   i_imm      immediate operand
//   o_acc_next accumulator value to load when the instruction retires
module acc_alu
  import acc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   i_ctrl,
  input  logic [5:0]   i_op,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_rs_data,
  input  logic [W-1:0] i_imm,
  output logic [W-1:0] o_acc_next
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_acc_next; a path
    // that leaves it unassigned would infer a latch.
    o_acc_next = i_acc;
    case (i_ctrl)
      CTRL_ALU: begin
        if (i_op[5:3] == OP_GRP_ADDI) begin
          o_acc_next = i_acc + i_imm;
        end else begin
          case (i_op[1:0])
            FN_ADD:  o_acc_next = i_acc + i_rs_data;
            FN_SUB:  o_acc_next = i_acc - i_rs_data;
            FN_AND:  o_acc_next = i_acc & i_rs_data;
            default: o_acc_next = i_acc | i_rs_data;
          endcase
        end
      end
      CTRL_UNARY: begin
        case (i_op[2:0])
          UN_SHL:  o_acc_next = {i_acc[W-2:0], 1'b0};
          UN_SHR:  o_acc_next = {1'b0, i_acc[W-1:1]};
          default: o_acc_next = i_acc;
        endcase
      end
      default: o_acc_next = i_acc;
    endcase
  end

endmodule

// File: rtl/acc_exec.sv
// Accumulator execution unit. Accepts one decoded instruction per handshake,
// owns the accumulator and equality flag, and sequences single-cycle ALU /
// compare / jump / register-write models and multi-cycle memory load/store
// handshakes with a timeout.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   in_valid / in_ready              instruction handshake
//   acc_ctrl, op, rs_idx             model code, raw opcode, LWR register index
//   rs_data, rt_data, imm            operands / address / jump target
//   acc, eq_flag                     architectural state
//   mem_req/we/addr/wdata, mem_ack/rdata   data memory handshake
//   reg_we/waddr/wdata               register file write port
//   jump_taken, jump_target          PC redirect request
//   done, illegal, mem_err           one-cycle status pulses
module acc_exec
  import acc_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   acc_ctrl,
  input  logic [5:0]   op,
  input  logic [2:0]   rs_idx,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  input  logic [W-1:0] imm,
  output logic [W-1:0] acc,
  output logic         eq_flag,
  output logic         mem_req,
  output logic         mem_we,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  output logic         reg_we,
  output logic [2:0]   reg_waddr,
  output logic [W-1:0] reg_wdata,
  output logic         jump_taken,
  output logic [W-1:0] jump_target,
  output logic         done,
  output logic         illegal,
  output logic         mem_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e         r_state, w_next_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   w_alu_acc;
  logic           w_accept, w_is_mem, w_timeout;

  assign w_accept  = in_valid && in_ready;
  assign w_is_mem  = (acc_ctrl == CTRL_ST) || (acc_ctrl == CTRL_LD);
  // The cycle that would make the wait count reach TIMEOUT aborts instead.
  assign w_timeout = (r_state == MEM) && !mem_ack && (r_cnt == CNT_LAST);

  acc_alu #(.W(W)) u_alu (
    .i_ctrl    (acc_ctrl),
    .i_op      (op),
    .i_acc     (acc),
    .i_rs_data (rs_data),
    .i_imm     (imm),
    .o_acc_next(w_alu_acc)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_is_mem) w_next_state = MEM;
      MEM:     if (mem_ack || w_timeout) w_next_state = RETIRE;
      // RETIRE spans two cycles: one to raise done, one while done is high.
      RETIRE:  if (done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready    <= 1'b1;
      acc         <= '0;
      eq_flag     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_waddr   <= '0;
      reg_wdata   <= '0;
      jump_taken  <= 1'b0;
      jump_target <= '0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      mem_err     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values; the pulse defaults below are then overridden where needed.
      done       <= 1'b0;
      illegal    <= 1'b0;
      mem_err    <= 1'b0;
      reg_we     <= 1'b0;
      jump_taken <= 1'b0;
      in_ready   <= (w_next_state == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (acc_ctrl)
              CTRL_ALU, CTRL_UNARY: begin
                acc  <= w_alu_acc;
                done <= 1'b1;
              end
              CTRL_EQ: begin
                eq_flag <= (rs_data == rt_data);
                done    <= 1'b1;
              end
              CTRL_JMP: begin
                if (eq_flag) begin
                  jump_taken  <= 1'b1;
                  jump_target <= imm;
                  eq_flag     <= 1'b0;
                end
                done <= 1'b1;
              end
              CTRL_LWR: begin
                reg_we    <= 1'b1;
                reg_waddr <= rs_idx;
                reg_wdata <= imm;
                done      <= 1'b1;
              end
              CTRL_ST, CTRL_LD: begin
                mem_req  <= 1'b1;
                mem_we   <= (acc_ctrl == CTRL_ST);
                mem_addr <= imm;
                if (acc_ctrl == CTRL_ST) mem_wdata <= acc;
                r_cnt    <= '0;
              end
              default: illegal <= 1'b1;
            endcase
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) acc <= mem_rdata;
          end else if (w_timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RETIRE: begin
          if (!done) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_exec.sv
// Self-checking bench for acc_exec: directed scenarios followed by random
// instruction streams, checked against a transaction-level model.
module tb_acc_exec;

  localparam int W       = 8;
  localparam int TIMEOUT = 15;
  localparam int MODW    = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   acc_ctrl;
  logic [5:0]   op;
  logic [2:0]   rs_idx;
  logic [W-1:0] rs_data, rt_data, imm;
  logic [W-1:0] acc;
  logic         eq_flag;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic         reg_we;
  logic [2:0]   reg_waddr;
  logic [W-1:0] reg_wdata;
  logic         jump_taken;
  logic [W-1:0] jump_target;
  logic         done, illegal, mem_err;

  acc_exec #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .acc_ctrl(acc_ctrl), .op(op), .rs_idx(rs_idx), .rs_data(rs_data),
    .rt_data(rt_data), .imm(imm), .acc(acc), .eq_flag(eq_flag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .jump_taken(jump_taken), .jump_target(jump_target), .done(done),
    .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Architectural state as the model sees it.
  int m_acc = 0;
  bit m_eq  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_acc(input int ctrl, input int opc, input int a,
                                 input int rs, input int im);
    if (ctrl == 1) begin
      if (((opc >> 3) & 7) == 2) return (a + im) % MODW;
      case (opc & 3)
        0:       return (a + rs) % MODW;
        1:       return (a + MODW - rs) % MODW;
        2:       return a & rs;
        default: return a | rs;
      endcase
    end
    if (ctrl == 2) begin
      if ((opc & 7) == 5) return (a * 2) % MODW;
      if ((opc & 7) == 6) return a / 2;
    end
    return a;
  endfunction

  // Issue one non-memory instruction; called and returning at a falling edge.
  task automatic single(input int ctrl, input int opc, input int ridx,
                        input int rs, input int rt, input int im);
    bit exp_jump;
    in_valid = 1'b1;
    acc_ctrl = 3'(ctrl); op = 6'(opc); rs_idx = 3'(ridx);
    rs_data = W'(rs); rt_data = W'(rt); imm = W'(im);
    check("ready_before_issue", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp_jump = 1'b0;
    case (ctrl)
      1, 2: m_acc = ref_acc(ctrl, opc, m_acc, rs, im);
      3:    m_eq = (rs == rt);
      4:    begin exp_jump = m_eq; m_eq = 1'b0; end
      default: ;
    endcase
    check("done", 32'(done), (ctrl == 0) ? 32'd0 : 32'd1);
    check("illegal", 32'(illegal), (ctrl == 0) ? 32'd1 : 32'd0);
    check("acc", 32'(acc), 32'(m_acc));
    check("eq_flag", 32'(eq_flag), 32'(m_eq));
    check("jump_taken", 32'(jump_taken), 32'(exp_jump));
    if (exp_jump) check("jump_target", 32'(jump_target), 32'(im));
    check("reg_we", 32'(reg_we), (ctrl == 7) ? 32'd1 : 32'd0);
    if (ctrl == 7) begin
      check("reg_waddr", 32'(reg_waddr), 32'(ridx));
      check("reg_wdata", 32'(reg_wdata), 32'(im));
    end
    check("ready_after_issue", 32'(in_ready), 32'd1);
  endtask

  // Issue a load/store. ack_n in 1..TIMEOUT: mem_ack is high at the n-th edge
  // after acceptance; ack_n == 0: never acknowledged, and a late ack follows
  // the abort.
  task automatic mem_op(input bit is_load, input int im, input int ack_n,
                        input int rdata);
    int req_cyc = 0, busy_cyc = 0, dones = 0, errs = 0, cyc = 0;
    in_valid = 1'b1;
    acc_ctrl = is_load ? 3'b110 : 3'b101;
    op = 6'($urandom); imm = W'(im);
    rs_data = W'($urandom); rt_data = W'($urandom);
    check("mem_ready_before", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("mem_addr", 32'(mem_addr), 32'(im));
    check("mem_we", 32'(mem_we), is_load ? 32'd0 : 32'd1);
    if (!is_load) check("mem_wdata", 32'(mem_wdata), 32'(m_acc));
    while (!in_ready && cyc < TIMEOUT + 8) begin
      if (mem_req) req_cyc++;
      busy_cyc++;
      if (done) dones++;
      if (mem_err) errs++;
      if (ack_n != 0) mem_ack = (cyc + 1 == ack_n);
      else            mem_ack = (cyc == TIMEOUT);
      mem_rdata = mem_ack ? W'(rdata) : W'($urandom);
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      cyc++;
    end
    if (is_load && ack_n != 0) m_acc = rdata;
    check("mem_req_cycles", 32'(req_cyc), (ack_n != 0) ? 32'(ack_n) : 32'(TIMEOUT));
    check("busy_cycles", 32'(busy_cyc), (ack_n != 0) ? 32'(ack_n + 2) : 32'(TIMEOUT + 2));
    check("mem_done_count", 32'(dones), 32'd1);
    check("mem_err_count", 32'(errs), (ack_n != 0) ? 32'd0 : 32'd1);
    check("mem_acc", 32'(acc), 32'(m_acc));
    check("mem_req_idle", 32'(mem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; acc_ctrl = '0; op = '0; rs_idx = '0;
    rs_data = '0; rt_data = '0; imm = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_eq", 32'(eq_flag), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_pulses", {27'd0, done, illegal, mem_err, reg_we, jump_taken}, 32'd0);
    check("rst_regs", 32'(mem_addr | mem_wdata | jump_target | reg_wdata | W'(reg_waddr)), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back ALU: addi 5, then sub rs=2.
    single(1, 6'b010000, 0, 0, 0, 5);
    single(1, 6'b000001, 0, 2, 0, 0);
    check("alu_chain_acc", 32'(acc), 32'd3);

    // Compare then jump twice.
    single(3, 0, 0, 7, 7, 0);
    single(4, 0, 0, 0, 0, 8'h40);
    single(4, 0, 0, 0, 0, 8'h41);

    // Load with ack at the third edge.
    mem_op(1'b1, 8'h10, 3, 8'hA5);

    // Force acc to 0x3C, then a store that times out with a late ack.
    single(1, 6'b000010, 0, 0, 0, 0);
    single(1, 6'b010000, 0, 0, 0, 8'h3C);
    mem_op(1'b0, 8'h20, 0, 0);
    // Load that times out: late ack with data must not reach acc.
    mem_op(1'b1, 8'h21, 0, 8'hEE);
    mem_op(1'b1, 8'h22, 1, 8'h5A);
    mem_op(1'b0, 8'h23, TIMEOUT, 0);

    // Illegal code and register write.
    single(3, 0, 0, 9, 9, 0);
    single(0, 6'h3F, 0, 1, 2, 3);
    single(7, 0, 4, 0, 0, 9);

    // Reset while waiting in MEM.
    in_valid = 1'b1; acc_ctrl = 3'b110; imm = 8'h30;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    m_acc = 0; m_eq = 1'b0;
    check("reset_mid_mem_req", 32'(mem_req), 32'd0);
    check("reset_mid_mem_acc", 32'(acc), 32'd0);
    check("reset_mid_mem_eq", 32'(eq_flag), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    single(1, 6'b010000, 0, 0, 0, 8'h11);

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      int ctrl, rs, rt;
      ctrl = $urandom_range(0, 7);
      rs = $urandom_range(0, MODW - 1);
      rt = ($urandom_range(0, 2) == 0) ? rs : $urandom_range(0, MODW - 1);
      if (ctrl == 5 || ctrl == 6) begin
        int n;
        n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT);
        mem_op(ctrl == 6, $urandom_range(0, MODW - 1), n, $urandom_range(0, MODW - 1));
      end else begin
        single(ctrl, $urandom_range(0, 63), $urandom_range(0, 7), rs, rt,
               $urandom_range(0, MODW - 1));
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
